// File: rtl/cordic_rotation_fsm_if.sv
// Request/response bundle for the rotation-mode CORDIC: phase and arctangent table in,
// sine/cosine plus done/busy status out.
interface cordic_rotation_fsm_if #(
    parameter int BIT_WIDTH = 24
);
    logic                        start_i;
    logic signed [BIT_WIDTH-1:0] phi_i;
    logic signed [BIT_WIDTH-1:0] angle_table [BIT_WIDTH];
    logic signed [BIT_WIDTH-1:0] sin_o;
    logic signed [BIT_WIDTH-1:0] cos_o;
    logic                        done_o;
    logic                        busy_o;

    modport master (
        output start_i, phi_i, angle_table,
        input  sin_o, cos_o, done_o, busy_o
    );

    modport slave (
        input  start_i, phi_i, angle_table,
        output sin_o, cos_o, done_o, busy_o
    );
endinterface

// File: rtl/cordic_rotation_fsm.sv
// Iterative rotation-mode CORDIC: phase word in Q2.(BIT_WIDTH-2) to sine/cosine,
// one micro-rotation per clock after a quadrant pre-rotation at the accepting edge.
module cordic_rotation_fsm #(
    parameter int BIT_WIDTH  = 24,
    parameter int ITERATIONS = BIT_WIDTH,
    parameter int K_INIT     = 2547003,
    parameter int PI_HALF    = 6588397
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    cordic_rotation_fsm_if.slave bus
);
    localparam int W  = BIT_WIDTH + 2;
    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [W-1:0] K_W    = W'(K_INIT);
    localparam logic signed [W-1:0] PI_H_W = W'(PI_HALF);
    localparam logic signed [W-1:0] SMAX   = {3'b000, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN   = {3'b111, {(BIT_WIDTH-1){1'b0}}};

    logic [1:0]          state;
    logic [IW-1:0]       i;
    logic signed [W-1:0] x, y, z;
    logic signed [W-1:0] xs, ys, ang, x_nx, y_nx, z_nx, phi_w;

    function automatic logic signed [BIT_WIDTH-1:0] sat(input logic signed [W-1:0] v);
        if (v > SMAX)      sat = SMAX[BIT_WIDTH-1:0];
        else if (v < SMIN) sat = SMIN[BIT_WIDTH-1:0];
        else               sat = v[BIT_WIDTH-1:0];
    endfunction

    // Micro-rotation datapath; direction follows the sign of the residual angle.
    always_comb begin
        xs    = x >>> i;
        ys    = y >>> i;
        ang   = W'(bus.angle_table[i]);
        phi_w = W'(bus.phi_i);
        if (!z[W-1]) begin
            x_nx = x - ys;
            y_nx = y + xs;
            z_nx = z - ang;
        end else begin
            x_nx = x + ys;
            y_nx = y - xs;
            z_nx = z + ang;
        end
    end

    assign bus.busy_o = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            i          <= '0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            bus.sin_o  <= '0;
            bus.cos_o  <= '0;
            bus.done_o <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        i     <= '0;
                        state <= S_ITER;
                        // Fold |phi| > pi/2 into the convergence range by a 90 degree pre-rotation.
                        if (phi_w > PI_H_W) begin
                            x <= '0;
                            y <= K_W;
                            z <= phi_w - PI_H_W;
                        end else if (phi_w < -PI_H_W) begin
                            x <= '0;
                            y <= -K_W;
                            z <= phi_w + PI_H_W;
                        end else begin
                            x <= K_W;
                            y <= '0;
                            z <= phi_w;
                        end
                    end
                end
                S_ITER: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    if (i == IW'(ITERATIONS - 1)) state <= S_DONE;
                    else                          i <= i + 1'b1;
                end
                S_DONE: begin
                    bus.sin_o  <= sat(y);
                    bus.cos_o  <= sat(x);
                    bus.done_o <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_rotation_fsm.sv
// Directed and random checks of the rotation-mode CORDIC against hand-computed and real-valued references.
module tb_cordic_rotation_fsm;
    localparam int BW = 24;
    localparam real SCALE = 4194304.0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cordic_rotation_fsm_if #(.BIT_WIDTH(BW)) bus ();

    cordic_rotation_fsm #(.BIT_WIDTH(BW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
        total++;
        if (obs - exp > tol || exp - obs > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single start pulse, then wait (bounded) for done; reports latency and busy-high cycle count.
    task automatic run(input int phi, output int s, output int c, output int lat, output int busy_cnt);
        bus.phi_i   = BW'(phi);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!bus.done_o && lat < 40) begin
            if (bus.busy_o) busy_cnt++;
            tick();
            lat++;
        end
        s = bus.sin_o;
        c = bus.cos_o;
    endtask

    int s, c, lat, bc, nd, dc;
    int dts[$];

    initial begin
        bus.start_i = 1'b0;
        bus.phi_i   = '0;
        for (int k = 0; k < BW; k++)
            bus.angle_table[k] = BW'(longint'($atan(2.0 ** (-k)) * SCALE));

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_sin", bus.sin_o, 0);
        chk("rst_cos", bus.cos_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_busy", bus.busy_o, 0);

        run(0, s, c, lat, bc);
        chk("zero_lat", lat, 25);
        chk("zero_busy", bc, 25);
        chk("zero_cos", c, 4194304, 16);
        chk("zero_sin", s, 0, 16);
        tick();
        chk("done_width", bus.done_o, 0);

        run(6588397, s, c, lat, bc);
        chk("p90_sin", s, 4194304, 16);
        chk("p90_cos", c, 0, 16);
        run(-6588397, s, c, lat, bc);
        chk("m90_sin", s, -4194304, 16);
        chk("m90_cos", c, 0, 16);
        run(3294198, s, c, lat, bc);
        chk("p45_sin", s, 2965821, 16);
        chk("p45_cos", c, 2965821, 16);
        run(-8388608, s, c, lat, bc);
        chk("m2_sin", s, -3813868, 16);
        chk("m2_cos", c, -1745447, 16);
        run(8388607, s, c, lat, bc);
        chk("p2_sin", s, 3813868, 16);
        chk("p2_cos", c, -1745447, 16);

        // Starts during ITER and in the DONE cycle must be dropped.
        bus.phi_i   = '0;
        bus.start_i = 1'b1;
        tick();
        nd = 0;
        dc = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            bus.start_i = (cyc == 3 || cyc == 24 || cyc == 25);
            if (cyc == 2) bus.phi_i = BW'(3294198);
            tick();
            if (bus.done_o) begin
                nd++;
                dc = cyc;
            end
        end
        bus.start_i = 1'b0;
        chk("ign_count", nd, 1);
        chk("ign_lat", dc, 25);
        chk("ign_phi_latched", bus.cos_o, 4194304, 16);

        // Held start: back-to-back conversions every ITERATIONS+2 cycles.
        bus.phi_i   = BW'(3294198);
        bus.start_i = 1'b1;
        dts.delete();
        for (int cyc = 0; cyc < 120 && dts.size() < 3; cyc++) begin
            tick();
            if (bus.done_o) dts.push_back(cyc);
        end
        bus.start_i = 1'b0;
        chk("held_pulses", dts.size(), 3);
        if (dts.size() == 3) begin
            chk("held_gap0", dts[1] - dts[0], 26);
            chk("held_gap1", dts[2] - dts[1], 26);
        end
        repeat (30) tick();

        // Reset mid-ITER, also with start held high across the reset edge.
        bus.phi_i   = BW'(1000000);
        bus.start_i = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_sin", bus.sin_o, 0);
        chk("midrst_cos", bus.cos_o, 0);
        chk("midrst_done", bus.done_o, 0);
        tick();
        chk("rst_prio_busy", bus.busy_o, 0);
        bus.start_i = 1'b0;
        rst = 1'b0;
        nd = 0;
        repeat (40) begin
            tick();
            if (bus.done_o) nd++;
        end
        chk("midrst_nodone", nd, 0);

        // Random phases across the full +/-2.0 rad range against a real-valued reference.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] r;
            logic signed [BW-1:0] ph;
            real a, es, ec, mag;
            int pv;
            r  = $urandom();
            ph = r[BW-1:0];
            pv = ph;
            a  = pv / SCALE;
            es = $sin(a) * SCALE;
            ec = $cos(a) * SCALE;
            run(pv, s, c, lat, bc);
            chk("rnd_sin", s, longint'(es), 16);
            chk("rnd_cos", c, longint'(ec), 16);
            mag = (real'(s) * real'(s) + real'(c) * real'(c)) / (SCALE * SCALE);
            chk("rnd_norm_ppm", longint'(mag * 1.0e6), 1000000, 1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
